// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector: hysteresis peak/trough detector for the filtered PPG stream.
//   CLK_Filter  : filter clock, all state rises on this edge
//   rst_n       : asynchronous reset, active-high
//   in_valid    : Filtered_In carries a new sample this cycle
//   Filtered_In : unsigned filtered sample
//   beat_pulse  : one-cycle strobe per accepted beat
//   period      : samples between the last two accepted peaks
//   peak_val    : latest accepted peak
//   trough_val  : latest confirmed trough
//   ac_amp      : peak_val - trough_val at the accepted beat, floored at 0
//   timeout     : sticky loss-of-pulse flag, cleared by the next accepted beat
module pulse_peak_detector #(
   parameter int DATA_W     = 20,
   parameter int CNT_W      = 12,
   parameter int HYST       = 256,
   parameter int MIN_PERIOD = 64,
   parameter int MAX_PERIOD = 4095
) (
   input  logic              CLK_Filter,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] Filtered_In,
   output logic              beat_pulse,
   output logic [CNT_W-1:0]  period,
   output logic [DATA_W-1:0] peak_val,
   output logic [DATA_W-1:0] trough_val,
   output logic [DATA_W-1:0] ac_amp,
   output logic              timeout
);
   typedef enum logic [1:0] {INIT, RISE, FALL} state_t;
   localparam logic [DATA_W-1:0] HYST_V = DATA_W'(HYST);
   localparam logic [CNT_W:0]    MIN_V  = (CNT_W+1)'(MIN_PERIOD);
   localparam logic [CNT_W-1:0]  MAX_V  = CNT_W'(MAX_PERIOD);
   state_t            state;
   logic [DATA_W-1:0] max_r, min_r, rise_d, fall_d;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [CNT_W:0]    len;
   logic              have_ref, pk_conf, tr_conf, lost, x_le_max, x_ge_min;
   assign x_le_max = Filtered_In <= max_r;
   assign x_ge_min = Filtered_In >= min_r;
   // differences only formed where the subtraction cannot wrap
   assign rise_d   = x_le_max ? max_r - Filtered_In : '0;
   assign fall_d   = x_ge_min ? Filtered_In - min_r : '0;
   assign pk_conf  = in_valid && state == RISE && x_le_max && rise_d >= HYST_V;
   assign tr_conf  = in_valid && state == FALL && x_ge_min && fall_d >= HYST_V;
   assign cnt_nxt  = (cnt == MAX_V) ? cnt : cnt + 1'b1;
   // len uses the pre-saturation count so a confirmation on the saturating sample measures correctly
   assign len      = (CNT_W+1)'(cnt) + 1'b1;
   assign lost     = cnt_nxt == MAX_V;
   always_ff @(posedge CLK_Filter or posedge rst_n) begin
      if (rst_n) begin
         state      <= INIT;
         max_r      <= '0;
         min_r      <= '0;
         cnt        <= '0;
         have_ref   <= 1'b0;
         beat_pulse <= 1'b0;
         period     <= '0;
         peak_val   <= '0;
         trough_val <= '0;
         ac_amp     <= '0;
         timeout    <= 1'b0;
      end else begin
         beat_pulse <= 1'b0;
         if (in_valid) begin
            cnt <= cnt_nxt;
            if (state == INIT) begin
               max_r <= Filtered_In;
               min_r <= Filtered_In;
               state <= RISE;
            end else if (state == RISE) begin
               if (!x_le_max) max_r <= Filtered_In;
               else if (pk_conf) begin
                  min_r <= Filtered_In;
                  state <= FALL;
               end
            end else begin
               if (!x_ge_min) min_r <= Filtered_In;
               else if (tr_conf) begin
                  trough_val <= min_r;
                  max_r      <= Filtered_In;
                  state      <= RISE;
               end
            end
            // loss of pulse first; a peak confirmation on the same sample overrides it below
            if (lost) begin
               timeout  <= 1'b1;
               have_ref <= 1'b0;
            end
            if (pk_conf) begin
               if (!have_ref) begin
                  peak_val <= max_r;
                  cnt      <= '0;
                  have_ref <= 1'b1;
               end else if (len >= MIN_V) begin
                  period     <= len[CNT_W-1:0];
                  peak_val   <= max_r;
                  ac_amp     <= (max_r >= trough_val) ? max_r - trough_val : '0;
                  beat_pulse <= 1'b1;
                  cnt        <= '0;
                  timeout    <= 1'b0;
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_pulse_peak_detector.sv
// tb_pulse_peak_detector: scoreboard bench for pulse_peak_detector.
module tb_pulse_peak_detector;
   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic [19:0] Filtered_In = '0;
   logic        beat_pulse, timeout;
   logic [11:0] period;
   logic [19:0] peak_val, trough_val, ac_amp;

   pulse_peak_detector dut (
      .CLK_Filter(clk), .rst_n(rst_n), .in_valid(in_valid), .Filtered_In(Filtered_In),
      .beat_pulse(beat_pulse), .period(period), .peak_val(peak_val),
      .trough_val(trough_val), .ac_amp(ac_amp), .timeout(timeout)
   );

   always #5 clk = ~clk;

   typedef struct {int per; int pk; int tr; int ac; int to;} beat_t;
   beat_t q[$];
   int    bcyc[$];
   int    n_test = 0, n_fail = 0, nbeat = 0, cyc = 0;
   int    ms, m_max, m_min, mcnt, mref, mper, mpk, mtr, mac, mto;

   task automatic check(string tag, int got, int exp);
      n_test++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      ms = 0; m_max = 0; m_min = 0; mcnt = 0; mref = 0;
      mper = 0; mpk = 0; mtr = 0; mac = 0; mto = 0;
      q.delete();
   endtask

   task automatic model(int x, bit v);
      bit pk, tr, lost;
      int len, ncnt, ref0;
      if (!v) return;
      pk   = ms == 1 && x <= m_max && m_max - x >= 256;
      tr   = ms == 2 && x >= m_min && x - m_min >= 256;
      len  = mcnt + 1;
      ncnt = len > 4095 ? 4095 : len;
      lost = ncnt == 4095;
      ref0 = mref;
      if (lost) begin mto = 1; mref = 0; end
      if (pk) begin
         if (ref0 == 0) begin
            mpk = m_max; ncnt = 0; mref = 1;
         end else if (len >= 64) begin
            mper = len; mpk = m_max; mac = m_max >= mtr ? m_max - mtr : 0;
            ncnt = 0; mto = 0;
            q.push_back('{mper, mpk, mtr, mac, mto});
         end
      end
      mcnt = ncnt;
      if (ms == 0) begin m_max = x; m_min = x; ms = 1; end
      else if (ms == 1) begin
         if (x > m_max) m_max = x;
         else if (pk) begin ms = 2; m_min = x; end
      end else begin
         if (x < m_min) m_min = x;
         else if (tr) begin mtr = m_min; ms = 1; m_max = x; end
      end
   endtask

   task automatic monitor();
      beat_t r;
      bit    exp_b;
      exp_b = q.size() > 0;
      if (beat_pulse || exp_b) check("beat", int'(beat_pulse), int'(exp_b));
      if (beat_pulse) begin nbeat++; bcyc.push_back(cyc); end
      if (exp_b) begin
         r = q.pop_front();
         if (beat_pulse) begin
            check("period", int'(period), r.per);
            check("peak_val", int'(peak_val), r.pk);
            check("trough_val", int'(trough_val), r.tr);
            check("ac_amp", int'(ac_amp), r.ac);
            check("timeout_at_beat", int'(timeout), r.to);
         end
      end
   endtask

   task automatic step(int x, bit v);
      Filtered_In = 20'(x);
      in_valid    = v;
      model(x, v);
      @(posedge clk);
      #1;
      cyc++;
      monitor();
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      rst_n    = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      nbeat = 0;
      bcyc.delete();
   endtask

   task automatic check_zero(string tag);
      check({tag, "_beat"}, int'(beat_pulse), 0);
      check({tag, "_period"}, int'(period), 0);
      check({tag, "_peak"}, int'(peak_val), 0);
      check({tag, "_trough"}, int'(trough_val), 0);
      check({tag, "_ac"}, int'(ac_amp), 0);
      check({tag, "_timeout"}, int'(timeout), 0);
   endtask

   function automatic int tri_v(int k);
      int p;
      p = k % 100;
      return p <= 50 ? 1000 + 80 * p : 1000 + 80 * (100 - p);
   endfunction

   int seg_slope[6] = '{80, -80, 80, -80, 80, -80};
   int seg_len[6]   = '{50, 19, 21, 52, 8, 8};

   initial begin
      int cur;
      model_reset();
      do_reset();
      check_zero("rst");

      // locked triangle: reference at k=54, beats at 154..454
      for (int k = 0; k < 500; k++) step(tri_v(k), 1'b1);
      check("tri_nbeat", nbeat, 4);
      check("tri_period", int'(period), 100);
      check("tri_peak", int'(peak_val), 5000);
      check("tri_trough", int'(trough_val), 1000);
      check("tri_ac", int'(ac_amp), 4000);
      check("tri_timeout", int'(timeout), 0);

      // flat 3000: cnt is 45 after the triangle, saturates on the 4050th flat sample
      nbeat = 0;
      for (int j = 0; j < 4049; j++) step(3000, 1'b1);
      check("flat_to_pre", int'(timeout), 0);
      step(3000, 1'b1);
      check("flat_to_set", int'(timeout), 1);
      check("flat_period_hold", int'(period), 100);
      for (int j = 0; j < 50; j++) step(3000, 1'b1);
      for (int k = 25; k <= 100; k++) step(tri_v(k), 1'b1);
      check("relock_ref_nobeat", nbeat, 0);
      check("relock_ref_to", int'(timeout), 1);
      for (int k = 101; k < 325; k++) step(tri_v(k), 1'b1);
      check("relock_nbeat", nbeat, 2);
      check("relock_period", int'(period), 100);
      check("relock_to_clr", int'(timeout), 0);

      // ripple below hysteresis: never confirms, timeout after 4095 samples
      do_reset();
      for (int k = 0; k < 4094; k++) step(2900 + ((k % 100) <= 50 ? 4 * (k % 100) : 4 * (100 - k % 100)), 1'b1);
      check("ripple_to_pre", int'(timeout), 0);
      step(2900 + 4 * 6, 1'b1);
      check("ripple_to_set", int'(timeout), 1);
      for (int k = 0; k < 5; k++) step(3000, 1'b1);
      check("ripple_nbeat", nbeat, 0);

      // refractory: ref at t=54, rejected peak at t=94, beat at t=154
      do_reset();
      cur = 1000;
      step(cur, 1'b1);
      for (int s = 0; s < 6; s++)
         for (int i = 0; i < seg_len[s]; i++) begin
            cur += seg_slope[s];
            step(cur, 1'b1);
         end
      check("refr_nbeat", nbeat, 1);
      check("refr_period", int'(period), 100);
      check("refr_peak", int'(peak_val), 1640);
      check("refr_ac", int'(ac_amp), 640);

      // half-rate in_valid with garbage on idle cycles
      do_reset();
      for (int k = 0; k < 300; k++) begin
         step(tri_v(k), 1'b1);
         step(int'($urandom_range(0, 1048575)), 1'b0);
      end
      check("half_nbeat", nbeat, 2);
      check("half_period", int'(period), 100);
      if (bcyc.size() == 2) check("half_spacing", bcyc[1] - bcyc[0], 200);
      else check("half_spacing_cnt", bcyc.size(), 2);

      // asynchronous reset mid-fall of a locked triangle
      do_reset();
      for (int k = 0; k < 170; k++) step(tri_v(k), 1'b1);
      check("mid_nbeat", nbeat, 1);
      in_valid = 1'b0;
      #2 rst_n = 1'b1;
      model_reset();
      #1 check_zero("async");
      @(posedge clk);
      #1 rst_n = 1'b0;
      nbeat = 0;
      for (int k = 171; k < 200; k++) step(tri_v(k), 1'b0);
      for (int k = 200; k < 460; k++) step(tri_v(k), 1'b1);
      check("post_rst_nbeat", nbeat, 2);
      check("post_rst_period", int'(period), 100);

      $display("[TB] %0d tests run, %0d failed", n_test, n_fail);
      $finish;
   end
endmodule

// File: doc/pulse_peak_detector.md
# pulse_peak_detector

Downstream stage of the FIR low-pass filter in the pulse-oximetry datapath. It consumes the 20-bit unsigned filtered PPG sample stream and detects systolic peaks and diastolic troughs using hysteresis. It measures the beat-to-beat interval in samples and reports peak, trough and AC amplitude per beat, for the heart-rate and SpO2 ratio logic.

## Interface
- DATA_W, 20: sample width; matches filter output.
- CNT_W, 12: interval counter and period width.
- HYST, 256: minimum excursion, in LSB, needed to confirm a peak or trough.
- MIN_PERIOD, 64: refractory interval in samples; shorter beats are rejected.
- MAX_PERIOD, 4095: interval at which the detector declares loss of pulse. Must be at most 2^CNT_W-1.

Ports:
- CLK_Filter  in  1  filter clock; all logic rises on this edge.
- rst_n  in  1  reset, asynchronous, active-high (1 = reset).
- in_valid  in  1  new sample present on Filtered_In; tie high when the block is fed directly every cycle.
- Filtered_In  in  DATA_W  unsigned filtered sample.
- beat_pulse  out  1  one-cycle strobe marking an accepted beat.
- period  out  CNT_W  samples between the last two accepted peaks.
- peak_val  out  DATA_W  latest accepted peak.
- trough_val  out  DATA_W  latest confirmed trough.
- ac_amp  out  DATA_W  peak_val minus trough_val at the accepted beat.
- timeout  out  1  sticky loss-of-pulse flag.

## Operation
- States:
  - INIT: waits for the first valid sample.
  - RISE: tracks the running maximum M.
  - FALL: tracks the running minimum m.
- All state, trackers and the counter update only on cycles with in_valid=1. With in_valid=0, everything holds and beat_pulse=0.
- INIT, first valid sample x: M<=x, m<=x, then go to RISE.
- RISE, sample x:
  - If x>M: M<=x.
  - Else if M-x>=HYST: the peak is confirmed. Go to FALL with m<=x.
- FALL, sample x:
  - If x<m: m<=x.
  - Else if x-m>=HYST: the trough is confirmed. trough_val<=m. Go to RISE with M<=x.
- Comparisons are unsigned. The difference is computed only on the branch where it cannot underflow.
- Interval counter cnt:
  - Increments on each valid sample and saturates at MAX_PERIOD.
  - Let len=cnt+1, computed CNT_W+1 bits wide.
- Peak confirmation handling, with internal flag have_ref (0 after reset):
  - have_ref=0: reference peak. peak_val<=M, cnt<=0, have_ref<=1. No beat_pulse.
  - have_ref=1 and len>=MIN_PERIOD: accepted beat.
    - period<=len, peak_val<=M, ac_amp<=M-trough_val, beat_pulse<=1, cnt<=0, timeout<=0.
    - If M<trough_val, ac_amp<=0 (saturate).
  - have_ref=1 and len<MIN_PERIOD: rejected. No output changes and cnt keeps counting. The state machine still moves to FALL.
- Loss of pulse:
  - Occurs when cnt reaches MAX_PERIOD.
  - Sets timeout<=1 and have_ref<=0. period, peak_val, trough_val and ac_amp hold.
  - The next confirmed peak becomes a new reference.
- Simultaneous events:
  - Peak confirmation on the same sample that saturates cnt is processed as confirmation. The len check uses the pre-saturation value.
  - A trough and a peak cannot confirm on the same sample.
- Reset, asynchronous, at any time:
  - State=INIT, cnt=0, have_ref=0.
  - All outputs 0: beat_pulse, period, peak_val, trough_val, ac_amp, timeout.

## Timing
- Fully registered outputs.
- beat_pulse, period, peak_val and ac_amp update on the clock edge that samples the confirming in_valid sample. They are visible in the following cycle.
- trough_val updates on the clock edge of the trough-confirming sample.
- Detection lag:
  - A peak confirms on the first sample at or below M-HYST.
  - Reported period is measured between confirmation samples, not between true extrema.
- beat_pulse is exactly one CLK_Filter cycle wide, even if in_valid stays high.
- Throughput: one sample per cycle, no stalls, no backpressure.

## Test plan
- Triangle wave, 1000→5000→1000, step 80, 50 up and 50 down (period 100), HYST=256:
  - First peak confirmation is reference only, with no pulse.
  - Each later beat gives beat_pulse, period=100, peak_val=5000, trough_val=1000, ac_amp=4000.
  - Each peak confirms at 4760−… on the fourth falling sample (4680).
- Same triangle with ±100 ripple riding on a DC level of 3000 only → no beat_pulse, timeout=1 after 4095 samples.
- Two peaks 40 samples apart, then a third peak 100 samples after the first:
  - The second peak is rejected with no pulse.
  - The third gives beat_pulse with period=100.
- Flat input of 3000 for 4100 samples after a locked triangle:
  - timeout rises at cnt=4095.
  - The next triangle peak is reference only.
  - The following peak gives period=100 and clears timeout.
- Triangle from the first case with in_valid high every other cycle → period=100, beat_pulse spacing 200 cycles.
- Assert rst_n for one cycle mid-fall of a locked triangle:
  - All outputs read 0 immediately.
  - The first post-reset peak is reference only.
  - The second gives period=100.
